// File: rtl/cipher_byte_serializer.sv
// Serializes one ciphertext block into a byte stream over valid/ready.
// The next block loads on the last-byte handshake, so back-to-back blocks stream without a bubble.
module cipher_byte_serializer #(
  parameter int DATA_W    = 128,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cipher_text,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [CNT_W-1:0]  blocks_sent
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] shreg, load_sh, adv_sh;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        first_byte, next_byte;
  logic              accept, byte_hs, last_hs;

  // shreg holds the bytes not yet presented, aligned so the next one sits at the send end
  assign first_byte = MSB_FIRST ? cipher_text[DATA_W-1 -: 8] : cipher_text[7:0];
  assign next_byte  = MSB_FIRST ? shreg[DATA_W-1 -: 8]       : shreg[7:0];
  assign load_sh    = MSB_FIRST ? (cipher_text << 8) : (cipher_text >> 8);
  assign adv_sh     = MSB_FIRST ? (shreg << 8)       : (shreg >> 8);

  assign accept  = in_valid && in_ready;
  assign byte_hs = out_valid && out_ready;
  assign last_hs = byte_hs && out_last;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        in_ready = out_ready && out_last;
        if (out_ready && out_last && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_byte    <= '0;
      out_last    <= 1'b0;
      idx         <= '0;
      shreg       <= '0;
      blocks_sent <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == SEND);
      if (last_hs) blocks_sent <= blocks_sent + 1'b1;
      if (accept) begin
        shreg    <= load_sh;
        idx      <= '0;
        out_byte <= first_byte;
        out_last <= (NB == 1);
      end else if (last_hs) begin
        idx      <= '0;
        out_byte <= '0;
        out_last <= 1'b0;
      end else if (byte_hs) begin
        shreg    <= adv_sh;
        idx      <= idx + 1'b1;
        out_byte <= next_byte;
        out_last <= (idx == IDX_W'(NB - 2));
      end
    end
  end
endmodule

// File: tb/tb_cipher_byte_serializer.sv
// Directed bench: default instance, a CNT_W=2 instance and an LSB-first instance share one stimulus stream.
module tb_cipher_byte_serializer;
  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [127:0] cipher_text;

  logic         a_in_ready, a_out_valid, a_out_last;
  logic [7:0]   a_out_byte;
  logic [15:0]  a_blocks;
  logic         b_in_ready, b_out_valid, b_out_last;
  logic [7:0]   b_out_byte;
  logic [1:0]   b_blocks;
  logic         c_in_ready, c_out_valid, c_out_last;
  logic [7:0]   c_out_byte;
  logic [15:0]  c_blocks;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] blk_a, blk_b;
  logic [7:0]   a_bytes [16];
  logic [7:0]   b_bytes [16];

  always #5 clk = ~clk;

  cipher_byte_serializer u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .cipher_text(cipher_text), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_byte(a_out_byte), .out_last(a_out_last), .blocks_sent(a_blocks));

  cipher_byte_serializer #(.CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .cipher_text(cipher_text), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_byte(b_out_byte), .out_last(b_out_last), .blocks_sent(b_blocks));

  cipher_byte_serializer #(.MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .cipher_text(cipher_text), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_byte(c_out_byte), .out_last(c_out_last), .blocks_sent(c_blocks));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] ea, input logic [7:0] ec,
                          input logic last);
    chk({tag, " a_valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, " a_byte"},  32'(a_out_byte),  32'(ea));
    chk({tag, " a_last"},  32'(a_out_last),  32'(last));
    chk({tag, " c_byte"},  32'(c_out_byte),  32'(ec));
    chk({tag, " c_last"},  32'(c_out_last),  32'(last));
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] ea_cnt, input logic [1:0] eb_cnt);
    chk({tag, " valid"},  32'(a_out_valid), 32'd0);
    chk({tag, " last"},   32'(a_out_last),  32'd0);
    chk({tag, " c_valid"}, 32'(c_out_valid), 32'd0);
    chk({tag, " a_cnt"},  32'(a_blocks),    32'(ea_cnt));
    chk({tag, " b_cnt"},  32'(b_blocks),    32'(eb_cnt));
  endtask

  initial begin
    int hs;
    int cyc;
    blk_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    blk_b = 128'h00112233445566778899aabbccddeeff;
    a_bytes = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    b_bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};

    // reset, with a block offered that must not be taken
    rst = 1'b1; in_valid = 1'b1; cipher_text = blk_a; out_ready = 1'b1;
    tick(); tick();
    chk("rst valid", 32'(a_out_valid), 32'd0);
    chk("rst byte",  32'(a_out_byte),  32'd0);
    chk("rst last",  32'(a_out_last),  32'd0);
    chk("rst cnt",   32'(a_blocks),    32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst no accept", 32'(a_out_valid), 32'd0);

    // reset mid-block, asserted while 0x70 is presented
    in_valid = 1'b1;
    #1;
    chk("idle in_ready", 32'(a_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 13; k++) begin
      chk_byte("midrst", a_bytes[k], a_bytes[15-k], 1'b0);
      if (k == 12) rst = 1'b1;
      tick();
    end
    chk("midrst valid", 32'(a_out_valid), 32'd0);
    chk("midrst byte",  32'(a_out_byte),  32'd0);
    chk("midrst last",  32'(a_out_last),  32'd0);
    chk("midrst cnt",   32'(a_blocks),    32'd0);
    rst = 1'b0;
    tick();

    // single block, full throughput
    in_valid = 1'b1; cipher_text = blk_a; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_byte("single", a_bytes[k], a_bytes[15-k], k == 15);
      tick();
    end
    chk_idle("single end", 16'd1, 2'd1);

    // backpressure: out_ready pattern 1,0,0 repeating
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 16 && cyc < 100) begin
      chk_byte("bp", a_bytes[hs], a_bytes[15-hs], hs == 15);
      out_ready = (cyc % 3 == 0);
      if (out_ready) hs++;
      cyc++;
      tick();
    end
    chk("bp budget", 32'(cyc < 100), 32'd1);
    out_ready = 1'b1;
    chk_idle("bp end", 16'd2, 2'd2);

    // back-to-back: second block held valid throughout the first
    in_valid = 1'b1; cipher_text = blk_a;
    tick();
    cipher_text = blk_b;
    for (int k = 0; k < 32; k++) begin
      if (k == 16) in_valid = 1'b0;
      #1;
      if (k < 16) chk_byte("b2b", a_bytes[k], a_bytes[15-k], k == 15);
      else        chk_byte("b2b", b_bytes[k-16], b_bytes[31-k], k == 31);
      chk("b2b in_ready", 32'(a_in_ready), 32'(k == 15 || k == 31));
      if (k == 16) begin
        chk("b2b mid a_cnt", 32'(a_blocks), 32'd3);
        chk("b2b mid b_cnt", 32'(b_blocks), 32'd3);
      end
      tick();
    end
    chk_idle("b2b end", 16'd4, 2'd0);

    // second block alone: LSB-first instance emits ff..00
    in_valid = 1'b1; cipher_text = blk_b;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_byte("lsb", b_bytes[k], b_bytes[15-k], k == 15);
      tick();
    end
    chk_idle("lsb end", 16'd5, 2'd1);
    chk("lsb c_cnt", 32'(c_blocks), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
